ram8_arbiter: RTL
=================

Name: ram8_arbiter

Overview:
- Round-robin arbiter that shares one RAM8 (eight 16-bit registers built from Bit cells) between 4 requesters.
- Issues one-cycle registered grants, drives the RAM8 in/load/address ports from the granted requester, and returns read data one cycle after the grant.
- Sits between the RAM8 and the client blocks that need shared scratch storage.

Parameters:
- N_REQ, 4, number of requesters (fixed at 4 for this revision).
- W, 16, data width, matching RAM8 word width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  per-requester access request; bit i = requester i.
- we  input  4  per-requester write enable; 1 = write, 0 = read.
- addr  input  12  requester i address at bits [3i+2:3i].
- wdata  input  64  requester i write data at bits [16i+15:16i].
- gnt  output  4  one-hot registered grant; high for exactly one cycle per access.
- rvalid  output  4  one-hot read-data-valid pulse.
- rdata  output  16  read data, shared by all requesters; qualified by rvalid.
- ram_in  output  16  to RAM8 in.
- ram_load  output  1  to RAM8 load.
- ram_address  output  3  to RAM8 address.
- ram_out  input  16  from RAM8 out (combinational read of the addressed word).

Behaviour:
- Reset (asynchronous, immediate):
  - gnt=0, rvalid=0, rdata=0.
  - Round-robin pointer ptr=3, so requester 0 has top priority after reset.
  - ram_load falls to 0 combinationally with gnt.
- Arbitration, evaluated every rising edge:
  - Eligible set: E = req & ~gnt. A requester in its grant cycle is masked, so it cannot be re-granted while its req is still high.
  - If E != 0: the next gnt is the first set bit of E scanning ptr+1, ptr+2, ... mod 4, and ptr takes that index.
  - If E == 0: gnt <= 0 and ptr holds.
  - Throughput is one access per cycle. Back-to-back grants to different requesters are allowed.
- Requester protocol:
  - Raise req with we/addr/wdata valid, then hold all four stable until gnt is seen high.
  - Drop req in the cycle after gnt, unless issuing a new access.
  - A requester that keeps req high gets its next grant no sooner than two cycles later, and only if no other requester is eligible. Priority rotation prevents starvation.
  - Dropping req before it is granted withdraws the request; no grant and no side effects.
- RAM drive, combinational from gnt:
  - While gnt[i]=1: ram_address=addr_i, ram_in=wdata_i, ram_load=we[i].
  - While gnt=0: ram_address=0, ram_in=0, ram_load=0.
  - Write takes effect at the edge that ends the grant cycle. A write grant needs no further response; gnt is the acknowledge.
- Read response:
  - At the edge ending a grant cycle with we[i]=0: rdata <= ram_out, rvalid <= one-hot i.
  - Otherwise rvalid <= 0 and rdata holds its last value.
  - Read latency: rvalid is high in the cycle after gnt, for exactly 1 cycle.
- Read-after-write: a read granted in the cycle immediately after a write to the same address returns the new data.
- Reset mid-access:
  - A grant cycle cut by reset performs no write (load deasserts asynchronously).
  - A pending rvalid is cancelled.
  - Requesters must re-request.
- Invariants to check: gnt and rvalid are always zero- or one-hot; ram_load=1 implies gnt != 0.

Test Plan:
- Reset, then req=0001, we=0001, addr0=5, wdata0=0x1234. Required: gnt=0001 for one cycle with ram_load=1, ram_address=5, ram_in=0x1234. Then a read of addr0=5 gives gnt, then rvalid=0001 with rdata=0x1234 on the following cycle.
- All four reads held high from reset. Required: grants in order 0001, 0010, 0100, 1000, 0001 on consecutive cycles; each rvalid follows its gnt by 1 cycle.
- Requester 2 writes addr 7 = 0xBEEF, then requester 3 reads addr 7 in the very next cycle. Required: rvalid=1000 with rdata=0xBEEF.
- req=0011 held continuously after ptr=0. Required: alternating gnt 0010, 0001, 0010, ... and no requester granted twice in a row.
- Assert reset during a write grant (addr 1, 0xFFFF) before the clock edge. Required: gnt and ram_load drop immediately; a later read of addr 1 returns the prior value (0 after power-up reset); no rvalid.
- Requester 1 raises req, then drops it before it is granted while requester 0 is being served. Required: requester 1 gets no grant, and ram_load only ever asserts for requester 0's accesses.

Source files
------------

// File: rtl/ram8_arbiter.sv
// ram8_arbiter: round-robin arbiter sharing one RAM8 between four requesters,
// with one-cycle registered grants and read data returned the cycle after grant.
module ram8_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   we,
    input  logic [3*N_REQ-1:0] addr,
    input  logic [W*N_REQ-1:0] wdata,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   rvalid,
    output logic [W-1:0]       rdata,
    output logic [W-1:0]       ram_in,
    output logic               ram_load,
    output logic [2:0]         ram_address,
    input  logic [W-1:0]       ram_out
);
    localparam int PW = $clog2(N_REQ);

    logic [N_REQ-1:0] gnt_q, gnt_d, rvalid_q, rvalid_d, elig, rd_hit;
    logic [PW-1:0]    ptr_q, ptr_d, idx;
    logic [W-1:0]     rdata_q, rdata_d;
    logic             found;

    // A requester in its grant cycle is masked so it cannot be re-granted back to back
    assign elig = req & ~gnt_q;

    always_comb begin
        gnt_d = '0;
        ptr_d = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = PW'((int'(ptr_q) + k) % N_REQ);
            if (!found && elig[idx]) begin
                found        = 1'b1;
                ptr_d        = idx;
                gnt_d[idx]   = 1'b1;
            end
        end
    end

    assign rd_hit   = gnt_q & ~we;
    assign rvalid_d = rd_hit;
    assign rdata_d  = |rd_hit ? ram_out : rdata_q;

    // gnt_q is one-hot or zero, so an OR-mux selects the granted requester
    always_comb begin
        ram_in      = '0;
        ram_load    = 1'b0;
        ram_address = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ram_in      |= {W{gnt_q[i]}} & wdata[W*i +: W];
            ram_load    |= gnt_q[i] & we[i];
            ram_address |= {3{gnt_q[i]}} & addr[3*i +: 3];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            ptr_q    <= PW'(N_REQ - 1);
        end else begin
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            ptr_q    <= ptr_d;
        end
    end

    assign gnt    = gnt_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
endmodule
